if_fetch_unit: RTL and testbench

Instruction fetch stage: owns the fetch PC, drives the instruction-memory read handshake, and delivers one instruction per accepted response to the IF/ID pipeline register. It sits directly upstream of IF/ID. It absorbs downstream stalls by holding the fetched word, and it handles redirects from the execute stage, including squashing a read that is already in flight.

---
 rtl/rv32i_types.sv | 24 ++
 rtl/if_predecode.sv | 17 +
 rtl/if_fetch_unit.sv | 150 +++++++++++++++
 tb/tb_if_fetch_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I types for the front end: opcodes, fetch FSM states, reset vector.
package rv32i_types;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011
    } rv32i_opcode;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h4000_0060;

endpackage

// File: rtl/if_predecode.sv
// Combinational jal detector: flags a jal word and computes its pc-relative target.
module if_predecode
    import rv32i_types::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] pc_i,
    output logic        is_jal_o,
    output logic [31:0] target_o
);

    logic [31:0] j_imm;

    assign j_imm    = {{12{word_i[31]}}, word_i[19:12], word_i[20], word_i[30:21], 1'b0};
    assign is_jal_o = (word_i[6:0] == op_jal);
    assign target_o = pc_i + j_imm;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC, I-cache handshake, stall hold and redirect squash.
// Optional jal predecode is enabled by defining IF_JAL_PREDECODE_EN.
module if_fetch_unit
    import rv32i_types::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_read_o,
    output logic [31:0] imem_address_o,
    input  logic [31:0] imem_rdata_i,
    input  logic        imem_resp_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] instruction_o,
    output logic        pred_taken_o,
    output logic [31:0] pred_target_o
);

    fetch_state_t state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  hold_word_q, hold_word_d;
    logic [31:0]  hold_pc_q, hold_pc_d;
    logic [31:0]  pending_pc_q, pending_pc_d;

    logic [31:0]  redirect_tgt;
    logic [31:0]  deliver_word;
    logic [31:0]  deliver_pc;
    logic [31:0]  next_pc;

    assign redirect_tgt = redirect_pc_i & 32'hFFFF_FFFC;
    assign deliver_word = (state_q == HOLD) ? hold_word_q : imem_rdata_i;
    assign deliver_pc   = (state_q == HOLD) ? hold_pc_q : fetch_pc_q;

`ifdef IF_JAL_PREDECODE_EN
    logic        pd_is_jal;
    logic [31:0] pd_target;

    if_predecode u_predecode (
        .word_i   (deliver_word),
        .pc_i     (deliver_pc),
        .is_jal_o (pd_is_jal),
        .target_o (pd_target)
    );

    assign next_pc       = pd_is_jal ? pd_target : deliver_pc + 32'd4;
    assign pred_taken_o  = valid_o & pd_is_jal;
    assign pred_target_o = pred_taken_o ? pd_target : 32'd0;
`else
    assign next_pc       = deliver_pc + 32'd4;
    assign pred_taken_o  = 1'b0;
    assign pred_target_o = 32'd0;
`endif

    assign imem_address_o = fetch_pc_q & 32'hFFFF_FFFC;

    // A redirect always kills the word being presented this cycle.
    always_comb begin
        imem_read_o   = 1'b0;
        valid_o       = 1'b0;
        pc_o          = rst ? fetch_pc_q : deliver_pc;
        instruction_o = 32'd0;
        if (!rst) begin
            unique case (state_q)
                REQ: begin
                    imem_read_o = 1'b1;
                    valid_o     = imem_resp_i & ~redirect_i;
                end
                HOLD:    valid_o     = ~redirect_i;
                DRAIN:   imem_read_o = 1'b1;
                default: ;
            endcase
        end
        if (valid_o) instruction_o = deliver_word;
    end

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        hold_word_d  = hold_word_q;
        hold_pc_d    = hold_pc_q;
        pending_pc_d = pending_pc_q;
        unique case (state_q)
            REQ: begin
                if (redirect_i) begin
                    if (imem_resp_i) begin
                        fetch_pc_d = redirect_tgt;
                    end else begin
                        pending_pc_d = redirect_tgt;
                        state_d      = DRAIN;
                    end
                end else if (imem_resp_i) begin
                    if (!stall_i) begin
                        fetch_pc_d = next_pc;
                    end else begin
                        hold_word_d = imem_rdata_i;
                        hold_pc_d   = fetch_pc_q;
                        state_d     = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect_i) begin
                    hold_word_d = 32'd0;
                    hold_pc_d   = 32'd0;
                    fetch_pc_d  = redirect_tgt;
                    state_d     = REQ;
                end else if (!stall_i) begin
                    fetch_pc_d = next_pc;
                    state_d    = REQ;
                end
            end
            DRAIN: begin
                // The stale response retires the old read; the latest target wins.
                if (redirect_i) begin
                    pending_pc_d = redirect_tgt;
                    if (imem_resp_i) begin
                        fetch_pc_d = redirect_tgt;
                        state_d    = REQ;
                    end
                end else if (imem_resp_i) begin
                    fetch_pc_d = pending_pc_q;
                    state_d    = REQ;
                end
            end
            default: state_d = REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= REQ;
            fetch_pc_q   <= RESET_PC;
            hold_word_q  <= 32'd0;
            hold_pc_q    <= 32'd0;
            pending_pc_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            hold_word_q  <= hold_word_d;
            hold_pc_q    <= hold_pc_d;
            pending_pc_q <= pending_pc_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a delivery scoreboard.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_read_o;
    logic [31:0] imem_address_o;
    logic [31:0] imem_rdata_i;
    logic        imem_resp_i;
    logic        valid_o;
    logic [31:0] pc_o;
    logic [31:0] instruction_o;
    logic        pred_taken_o;
    logic [31:0] pred_target_o;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

`ifdef IF_JAL_PREDECODE_EN
    localparam bit PD = 1'b1;
`else
    localparam bit PD = 1'b0;
`endif

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (stall_i),
        .redirect_i     (redirect_i),
        .redirect_pc_i  (redirect_pc_i),
        .imem_read_o    (imem_read_o),
        .imem_address_o (imem_address_o),
        .imem_rdata_i   (imem_rdata_i),
        .imem_resp_i    (imem_resp_i),
        .valid_o        (valid_o),
        .pc_o           (pc_o),
        .instruction_o  (instruction_o),
        .pred_taken_o   (pred_taken_o),
        .pred_target_o  (pred_target_o)
    );

    // Opcode field is always op-imm so ordinary words never look like jal.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[24:0], 7'h13};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic resp, input logic [31:0] rdata, input logic stall,
                         input logic redir, input logic [31:0] rpc);
        imem_resp_i   = resp;
        imem_rdata_i  = rdata;
        stall_i       = stall;
        redirect_i    = redir;
        redirect_pc_i = rpc;
        #1;
    endtask

    // Any transfer this cycle must match the oldest scoreboard entry.
    task automatic tick();
        exp_t e;
        if (valid_o && !stall_i) begin
            chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("xfer_pc", pc_o, e.pc);
                chk("xfer_instr", instruction_o, e.word);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_ok(input logic [31:0] a);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("req_read", imem_read_o, 32'd1);
        chk("req_addr", imem_address_o, a);
        chk("req_novalid", valid_o, 32'd0);
        tick();
        drive(1'b1, mem_word(a), 1'b0, 1'b0, 32'd0);
        sb.push_back('{pc: a, word: mem_word(a)});
        chk("resp_valid", valid_o, 32'd1);
        tick();
    endtask

    initial begin
        logic [31:0] npc;
        rst = 1'b1;
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_read", imem_read_o, 32'd0);
        chk("rst_valid", valid_o, 32'd0);
        chk("rst_pc", pc_o, 32'h4000_0060);
        chk("rst_instr", instruction_o, 32'd0);
        chk("rst_ptaken", pred_taken_o, 32'd0);
        chk("rst_ptarget", pred_target_o, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        fetch_ok(32'h4000_0060);

        // stall on the resp at _64: three stalled presentations, then release
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("st_addr", imem_address_o, 32'h4000_0064);
        tick();
        drive(1'b1, mem_word(32'h4000_0064), 1'b1, 1'b0, 32'd0);
        sb.push_back('{pc: 32'h4000_0064, word: mem_word(32'h4000_0064)});
        chk("st_valid0", valid_o, 32'd1);
        chk("st_instr0", instruction_o, mem_word(32'h4000_0064));
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
            chk("hold_read", imem_read_o, 32'd0);
            chk("hold_valid", valid_o, 32'd1);
            chk("hold_instr", instruction_o, mem_word(32'h4000_0064));
            chk("hold_pc", pc_o, 32'h4000_0064);
            tick();
        end
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("hold_rel_read", imem_read_o, 32'd0);
        chk("hold_rel_valid", valid_o, 32'd1);
        tick();
        fetch_ok(32'h4000_0068);

        // redirect one cycle after the read at _6C issues; stale resp two cycles later
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("rd_addr", imem_address_o, 32'h4000_006C);
        tick();
        drive(1'b0, 32'd0, 1'b0, 1'b1, 32'h4000_1001);
        chk("rd_valid", valid_o, 32'd0);
        chk("rd_read", imem_read_o, 32'd1);
        tick();
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("drain_read", imem_read_o, 32'd1);
        chk("drain_addr", imem_address_o, 32'h4000_006C);
        chk("drain_valid", valid_o, 32'd0);
        tick();
        drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd0);
        chk("stale_valid", valid_o, 32'd0);
        chk("stale_instr", instruction_o, 32'd0);
        tick();
        fetch_ok(32'h4000_1000);

        // two redirects back to back, latest target wins
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("rr_addr", imem_address_o, 32'h4000_1004);
        tick();
        drive(1'b0, 32'd0, 1'b0, 1'b1, 32'h4000_2000);
        tick();
        drive(1'b0, 32'd0, 1'b0, 1'b1, 32'h4000_3000);
        chk("rr_valid", valid_o, 32'd0);
        chk("rr_drain_addr", imem_address_o, 32'h4000_1004);
        tick();
        drive(1'b1, 32'hBAD0_0013, 1'b0, 1'b0, 32'd0);
        chk("rr_stale_valid", valid_o, 32'd0);
        tick();
        fetch_ok(32'h4000_3000);

        // redirect from HOLD while still stalled: held word dropped
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("hr_addr", imem_address_o, 32'h4000_3004);
        tick();
        drive(1'b1, mem_word(32'h4000_3004), 1'b1, 1'b0, 32'd0);
        chk("hr_instr", instruction_o, mem_word(32'h4000_3004));
        tick();
        drive(1'b0, 32'd0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        chk("hr_valid", valid_o, 32'd0);
        tick();
        fetch_ok(32'hFFFF_FFFC);
        fetch_ok(32'h0000_0000);

        // redirect with resp in the same REQ cycle
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("rq_addr", imem_address_o, 32'h0000_0004);
        tick();
        drive(1'b1, mem_word(32'h4), 1'b0, 1'b1, 32'h4000_0060);
        chk("rq_valid", valid_o, 32'd0);
        tick();

        // jal predecode
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("jal_addr", imem_address_o, 32'h4000_0060);
        tick();
        drive(1'b1, 32'h0100_006F, 1'b0, 1'b0, 32'd0);
        sb.push_back('{pc: 32'h4000_0060, word: 32'h0100_006F});
        chk("jal_valid", valid_o, 32'd1);
        chk("jal_ptaken", pred_taken_o, 32'(PD));
        chk("jal_ptarget", pred_target_o, PD ? 32'h4000_0070 : 32'd0);
        tick();
        npc = PD ? 32'h4000_0070 : 32'h4000_0064;
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("jal_next_read", imem_read_o, 32'd1);
        chk("jal_next_addr", imem_address_o, npc);
        tick();

        // reset in the middle of DRAIN abandons the read
        drive(1'b0, 32'd0, 1'b0, 1'b1, 32'h4000_5000);
        tick();
        rst = 1'b1;
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("rdr_read", imem_read_o, 32'd0);
        chk("rdr_valid", valid_o, 32'd0);
        tick();
        rst = 1'b0;
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("rdr_post_read", imem_read_o, 32'd1);
        chk("rdr_post_addr", imem_address_o, 32'h4000_0060);
        chk("rdr_post_valid", valid_o, 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
